fp_decode_stage: RTL and testbench

FP_DECODE_STAGE -- requirements
Module: fp_decode_stage

---
 rtl/fp_decode_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_decode_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_decode_stage.sv
// fp_decode_stage: decodes RISC-V F/D instructions at the input and queues
// the decoded records in a small circular FIFO. Output fields come straight
// from the queue head, so a downstream stall never re-decodes anything.
module fp_decode_stage #(
  parameter int RVD   = 1,
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_ready_o,
  input  logic [2:0]  frm_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  op_o,
  output logic        op_mod_o,
  output logic [2:0]  src_fmt_o,
  output logic [2:0]  dst_fmt_o,
  output logic [2:0]  rnd_mode_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rs3_o,
  output logic [4:0]  rd_o,
  output logic        fp_we_o,
  output logic        int_we_o,
  output logic        load_o,
  output logic        store_o,
  output logic        illegal_o,
  output logic [15:0] illegal_cnt_o
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int REC_W = 39;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Opcodes
  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;
  localparam logic [6:0] OPC_MADD  = 7'b1000011;
  localparam logic [6:0] OPC_MSUB  = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB = 7'b1001011;
  localparam logic [6:0] OPC_NMADD = 7'b1001111;
  localparam logic [6:0] OPC_OPFP  = 7'b1010011;

  // fpnew operation / format / rounding encodings
  localparam logic [3:0] OP_FMADD = 4'd0,  OP_FNMSUB = 4'd1, OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3,  OP_DIV    = 4'd4, OP_SQRT = 4'd5;
  localparam logic [3:0] OP_SGNJ  = 4'd6,  OP_MINMAX = 4'd7, OP_CMP  = 4'd8;
  localparam logic [3:0] OP_CLASS = 4'd9,  OP_F2F    = 4'd10;
  localparam logic [3:0] OP_F2I   = 4'd11, OP_I2F    = 4'd12;
  localparam logic [2:0] FMT_FP32 = 3'd0, FMT_FP64 = 3'd1;
  localparam logic [2:0] RM_RUP   = 3'd3;

  localparam logic RVD_EN = (RVD != 0);

  logic [6:0] w_opc;
  logic [2:0] w_rm, w_rm_res, w_fmt;
  logic [4:0] w_f5, w_rs2;
  logic       w_fmt_ok, w_ok, w_uses_rm, w_to_int, w_is_ld, w_is_st, w_mod;
  logic [3:0] w_op;
  logic [2:0] w_src, w_dst, w_rnd;
  logic [REC_W-1:0] w_rec, w_head;
  logic       w_push, w_pop, w_head_illegal;

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [15:0]      r_illegal_cnt;
  logic [REC_W-1:0] r_mem [DEPTH];

  assign w_opc    = instr_rdata_i[6:0];
  assign w_rm     = instr_rdata_i[14:12];
  assign w_f5     = instr_rdata_i[31:27];
  assign w_rs2    = instr_rdata_i[24:20];
  assign w_rm_res = (w_rm == 3'b111) ? frm_i : w_rm;

  // Operand format: funct3 for loads/stores, fmt field for everything else
  always_comb begin
    w_fmt    = FMT_FP32;
    w_fmt_ok = 1'b0;
    if (w_opc == OPC_LOAD || w_opc == OPC_STORE) begin
      w_fmt    = {2'b00, w_rm[0]};
      w_fmt_ok = (w_rm == 3'b010) || (w_rm == 3'b011 && RVD_EN);
    end else begin
      w_fmt    = {1'b0, instr_rdata_i[26:25]};
      w_fmt_ok = (instr_rdata_i[26:25] == 2'b00) ||
                 (instr_rdata_i[26:25] == 2'b01 && RVD_EN);
    end
  end

  // Opcode/funct decode into operation, modifier and legality
  always_comb begin
    w_ok      = w_fmt_ok;
    w_uses_rm = 1'b0;
    w_to_int  = 1'b0;
    w_is_ld   = 1'b0;
    w_is_st   = 1'b0;
    w_op      = OP_FMADD;
    w_mod     = 1'b0;
    w_src     = w_fmt;
    w_dst     = w_fmt;
    w_rnd     = w_rm_res;
    case (w_opc)
      OPC_LOAD:  w_is_ld = 1'b1;
      OPC_STORE: w_is_st = 1'b1;
      OPC_MADD:  begin w_op = OP_FMADD;  w_uses_rm = 1'b1; end
      OPC_MSUB:  begin w_op = OP_FMADD;  w_mod = 1'b1; w_uses_rm = 1'b1; end
      OPC_NMSUB: begin w_op = OP_FNMSUB; w_uses_rm = 1'b1; end
      OPC_NMADD: begin w_op = OP_FNMSUB; w_mod = 1'b1; w_uses_rm = 1'b1; end
      OPC_OPFP: begin
        case (w_f5)
          5'b00000: begin w_op = OP_ADD; w_uses_rm = 1'b1; end
          5'b00001: begin w_op = OP_ADD; w_mod = 1'b1; w_uses_rm = 1'b1; end
          5'b00010: begin w_op = OP_MUL; w_uses_rm = 1'b1; end
          5'b00011: begin w_op = OP_DIV; w_uses_rm = 1'b1; end
          5'b01011: begin
            w_op = OP_SQRT; w_uses_rm = 1'b1;
            if (w_rs2 != 5'd0) w_ok = 1'b0;
          end
          5'b00100: begin
            w_op = OP_SGNJ;
            if (w_rm > 3'b010) w_ok = 1'b0;
          end
          5'b00101: begin
            w_op = OP_MINMAX;
            if (w_rm > 3'b001) w_ok = 1'b0;
          end
          5'b10100: begin
            w_op = OP_CMP; w_to_int = 1'b1;
            if (w_rm > 3'b010) w_ok = 1'b0;
          end
          5'b11000: begin
            w_op = OP_F2I; w_mod = w_rs2[0]; w_to_int = 1'b1; w_uses_rm = 1'b1;
            if (w_rs2[4:1] != 4'd0) w_ok = 1'b0;
          end
          5'b11010: begin
            w_op = OP_I2F; w_mod = w_rs2[0]; w_uses_rm = 1'b1;
            if (w_rs2[4:1] != 4'd0) w_ok = 1'b0;
          end
          5'b01000: begin
            // Conversion between FP formats: source format lives in rs2
            w_op = OP_F2F; w_uses_rm = 1'b1;
            w_src = {2'b00, w_rs2[0]};
            if (!RVD_EN || w_rs2[4:1] != 4'd0 || w_src == w_fmt) w_ok = 1'b0;
          end
          5'b11100: begin
            w_to_int = 1'b1;
            if (w_rs2 == 5'd0 && w_rm == 3'b000) begin
              w_op = OP_SGNJ; w_rnd = RM_RUP;
            end else if (w_rs2 == 5'd0 && w_rm == 3'b001) begin
              w_op = OP_CLASS;
            end else begin
              w_ok = 1'b0;
            end
          end
          5'b11110: begin
            w_op = OP_SGNJ; w_rnd = RM_RUP;
            if (w_rs2 != 5'd0 || w_rm != 3'b000) w_ok = 1'b0;
          end
          default: w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
    if (w_uses_rm && w_rm_res[2] && (w_rm_res[1] || w_rm_res[0])) w_ok = 1'b0;
  end

  assign w_rec = {w_op, w_mod, w_src, w_dst, w_rnd,
                  instr_rdata_i[19:15], w_rs2, w_f5, instr_rdata_i[11:7],
                  w_ok && !w_is_st && !w_to_int,
                  w_ok && w_to_int,
                  w_ok && w_is_ld,
                  w_ok && w_is_st,
                  !w_ok};

  assign out_valid_o    = (r_count != '0);
  assign instr_ready_o  = (r_count != CNT_FULL);
  assign w_push         = instr_valid_i && instr_ready_o;
  assign w_pop          = out_valid_o && out_ready_i;
  assign w_head         = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign w_head_illegal = w_head[0];
  assign illegal_cnt_o  = r_illegal_cnt;

  assign {op_o, op_mod_o, src_fmt_o, dst_fmt_o, rnd_mode_o,
          rs1_o, rs2_o, rs3_o, rd_o,
          fp_we_o, int_we_o, load_o, store_o, illegal_o} = w_head;

  // Queue pointers, occupancy and popped-illegal counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_pop && w_head_illegal && r_illegal_cnt != 16'hFFFF)
        r_illegal_cnt <= r_illegal_cnt + 16'd1;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Record storage; unread slots are masked at the output, so no reset needed
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= w_rec;
  end

endmodule

// File: tb/tb_fp_decode_stage.sv
// Bench for fp_decode_stage: directed scenarios plus a randomized run
// against a queue-based reference model of the decoder.
module tb_fp_decode_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0] op;
    logic       mod;
    logic [2:0] src;
    logic [2:0] dst;
    logic [2:0] rnd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
    logic       fp_we;
    logic       int_we;
    logic       load;
    logic       store;
    logic       illegal;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  frm = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        instr_ready, out_valid, op_mod, fp_we, int_we, load, store, illegal;
  logic [3:0]  op;
  logic [2:0]  src_fmt, dst_fmt, rnd_mode;
  logic [4:0]  rs1, rs2, rs3, rd;
  logic [15:0] illegal_cnt;

  logic        n_valid = 1'b0;
  logic [31:0] n_instr = '0;
  logic        n_oready = 1'b0;
  logic        n_iready, n_ovalid, n_mod, n_fp_we, n_int_we, n_load, n_store, n_illegal;
  logic [3:0]  n_op;
  logic [2:0]  n_src, n_dst, n_rnd;
  logic [4:0]  n_rs1, n_rs2, n_rs3, n_rd;
  logic [15:0] n_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_decode_stage #(.RVD(1), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .instr_rdata_i(instr),
    .instr_ready_o(instr_ready), .frm_i(frm), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .op_o(op), .op_mod_o(op_mod), .src_fmt_o(src_fmt), .dst_fmt_o(dst_fmt),
    .rnd_mode_o(rnd_mode), .rs1_o(rs1), .rs2_o(rs2), .rs3_o(rs3), .rd_o(rd),
    .fp_we_o(fp_we), .int_we_o(int_we), .load_o(load), .store_o(store),
    .illegal_o(illegal), .illegal_cnt_o(illegal_cnt)
  );

  fp_decode_stage #(.RVD(0), .DEPTH(4)) dut_nd (
    .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(n_valid), .instr_rdata_i(n_instr),
    .instr_ready_o(n_iready), .frm_i(3'b000), .flush_i(1'b0),
    .out_valid_o(n_ovalid), .out_ready_i(n_oready),
    .op_o(n_op), .op_mod_o(n_mod), .src_fmt_o(n_src), .dst_fmt_o(n_dst),
    .rnd_mode_o(n_rnd), .rs1_o(n_rs1), .rs2_o(n_rs2), .rs3_o(n_rs3), .rd_o(n_rd),
    .fp_we_o(n_fp_we), .int_we_o(n_int_we), .load_o(n_load), .store_o(n_store),
    .illegal_o(n_illegal), .illegal_cnt_o(n_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_opfp(input logic [4:0] f5, input logic [1:0] fmt,
                                          input logic [4:0] r2, input logic [2:0] rm,
                                          input logic [4:0] rdv);
    return {f5, fmt, r2, 5'd2, rm, rdv, 7'b1010011};
  endfunction

  // Reference decoder written from the instruction-set rules
  function automatic rec_t ref_decode(input logic [31:0] ins, input logic [2:0] f, input bit rvd);
    rec_t e;
    logic [6:0] opc;
    logic [2:0] rm, rmr;
    logic [4:0] r2;
    logic [1:0] ff;
    bit ok, rnd_used, st, ld, toint;
    int fmt;
    e = '0;
    opc = ins[6:0]; rm = ins[14:12]; r2 = ins[24:20]; ff = ins[26:25];
    e.rs1 = ins[19:15]; e.rs2 = r2; e.rs3 = ins[31:27]; e.rd = ins[11:7];
    rmr = (rm == 3'd7) ? f : rm;
    e.rnd = rmr;
    ok = 1; rnd_used = 0; st = 0; ld = 0; toint = 0;
    if (opc == 7'h07 || opc == 7'h27) fmt = (rm == 3'd2) ? 0 : (rm == 3'd3) ? 1 : -1;
    else                              fmt = (ff == 2'd0) ? 0 : (ff == 2'd1) ? 1 : -1;
    if (fmt < 0 || (fmt == 1 && !rvd)) ok = 0;
    e.src = (fmt == 1) ? 3'd1 : 3'd0;
    e.dst = e.src;
    case (opc)
      7'h07: ld = 1;
      7'h27: st = 1;
      7'h43: begin e.op = 4'd0; rnd_used = 1; end
      7'h47: begin e.op = 4'd0; e.mod = 1; rnd_used = 1; end
      7'h4B: begin e.op = 4'd1; rnd_used = 1; end
      7'h4F: begin e.op = 4'd1; e.mod = 1; rnd_used = 1; end
      7'h53: begin
        case (ins[31:27])
          5'h00: begin e.op = 4'd2; rnd_used = 1; end
          5'h01: begin e.op = 4'd2; e.mod = 1; rnd_used = 1; end
          5'h02: begin e.op = 4'd3; rnd_used = 1; end
          5'h03: begin e.op = 4'd4; rnd_used = 1; end
          5'h0B: begin e.op = 4'd5; rnd_used = 1; if (r2 != 0) ok = 0; end
          5'h04: begin e.op = 4'd6; if (rm > 2) ok = 0; end
          5'h05: begin e.op = 4'd7; if (rm > 1) ok = 0; end
          5'h14: begin e.op = 4'd8; toint = 1; if (rm > 2) ok = 0; end
          5'h18: begin e.op = 4'd11; e.mod = r2[0]; toint = 1; rnd_used = 1; if (r2 > 1) ok = 0; end
          5'h1A: begin e.op = 4'd12; e.mod = r2[0]; rnd_used = 1; if (r2 > 1) ok = 0; end
          5'h08: begin
            e.op = 4'd10; rnd_used = 1;
            e.src = (r2 == 5'd1) ? 3'd1 : 3'd0;
            if (!rvd || r2 > 1 || e.src == e.dst) ok = 0;
          end
          5'h1C: begin
            toint = 1;
            if (r2 == 0 && rm == 0)      begin e.op = 4'd6; e.rnd = 3'd3; end
            else if (r2 == 0 && rm == 1) e.op = 4'd9;
            else                         ok = 0;
          end
          5'h1E: begin
            e.op = 4'd6; e.rnd = 3'd3;
            if (r2 != 0 || rm != 0) ok = 0;
          end
          default: ok = 0;
        endcase
      end
      default: ok = 0;
    endcase
    if (rnd_used && rmr >= 3'd5) ok = 0;
    e.illegal = !ok;
    e.fp_we   = ok && !st && !toint;
    e.int_we  = ok && toint;
    e.load    = ok && ld;
    e.store   = ok && st;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [4:0] f5, r2;
    logic [1:0] ff;
    logic [2:0] rm;
    case ($urandom_range(0, 9))
      0: opc = 7'h07;  1: opc = 7'h27;  2: opc = 7'h43;  3: opc = 7'h47;
      4: opc = 7'h4B;  5: opc = 7'h4F;  9: opc = 7'($urandom);
      default: opc = 7'h53;
    endcase
    case ($urandom_range(0, 13))
      0: f5 = 5'h00;  1: f5 = 5'h01;  2: f5 = 5'h02;  3: f5 = 5'h03;
      4: f5 = 5'h0B;  5: f5 = 5'h04;  6: f5 = 5'h05;  7: f5 = 5'h14;
      8: f5 = 5'h18;  9: f5 = 5'h1A; 10: f5 = 5'h08; 11: f5 = 5'h1C;
      12: f5 = 5'h1E; default: f5 = 5'($urandom);
    endcase
    ff = ($urandom_range(0, 3) == 0) ? 2'($urandom) : {1'b0, 1'($urandom)};
    r2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 1)) : 5'($urandom);
    rm = 3'($urandom);
    if ((opc == 7'h07 || opc == 7'h27) && $urandom_range(0, 3) != 0) rm = 3'($urandom_range(2, 3));
    return {f5, ff, r2, 5'($urandom), rm, 5'($urandom), opc};
  endfunction

  rec_t q[$];
  rec_t obs_r, exp_r, msk;
  int unsigned exp_cnt;
  logic [31:0] ins_a;

  initial begin
    // Reset state
    #12;
    check("rst_vld", out_valid, 1'b0);
    check("rst_rdy", instr_ready, 1'b1);
    check("rst_cnt", illegal_cnt, 16'd0);
    check("rst_op", op, 4'd0);
    check("rst_fmt", {src_fmt, dst_fmt, rnd_mode}, 9'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // FADD.S into an empty queue
    instr_valid = 1'b1; instr = 32'h003100D3; out_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("fadd_vld", out_valid, 1'b1);
    check("fadd_op", op, 4'd2);
    check("fadd_src", src_fmt, 3'd0);
    check("fadd_rnd", rnd_mode, 3'd0);
    check("fadd_rd", rd, 5'd1);
    check("fadd_we", {fp_we, int_we, illegal}, 3'b100);
    tick();
    check("fadd_drain", out_valid, 1'b0);

    // FMUL.S with dynamic rounding; frm changes after push to show it was captured
    ins_a = mk_opfp(5'h02, 2'b00, 5'd3, 3'b111, 5'd4);
    instr_valid = 1'b1; instr = ins_a; frm = 3'b001;
    tick();
    instr_valid = 1'b0; frm = 3'b000;
    check("fmul_rnd", rnd_mode, 3'd1);
    check("fmul_op", {op, illegal}, {4'd3, 1'b0});
    tick();
    instr_valid = 1'b1; frm = 3'b101;
    tick();
    instr_valid = 1'b0; frm = 3'b000;
    check("fmul_ill", {illegal, fp_we}, 2'b10);
    check("fmul_cnt0", illegal_cnt, 16'd0);
    tick();
    check("fmul_cnt1", illegal_cnt, 16'd1);

    // FLD with and without the D extension
    ins_a = {12'h010, 5'd1, 3'b011, 5'd5, 7'b0000111};
    instr_valid = 1'b1; instr = ins_a; n_valid = 1'b1; n_instr = ins_a; out_ready = 1'b0;
    tick();
    instr_valid = 1'b0; n_valid = 1'b0;
    check("fld_d", {load, src_fmt, illegal, fp_we}, {1'b1, 3'd1, 1'b0, 1'b1});
    check("fld_nod", {n_illegal, n_load, n_fp_we}, 3'b100);
    out_ready = 1'b1; n_oready = 1'b1;
    tick();
    n_oready = 1'b0;
    check("fld_nod_cnt", n_cnt, 16'd1);
    check("fld_d_cnt", illegal_cnt, 16'd1);

    // Backpressure on a 2-entry queue
    out_ready = 1'b0; instr_valid = 1'b1; instr = mk_opfp(5'h00, 2'b00, 5'd0, 3'b000, 5'd1);
    tick();
    check("bp_rdy1", instr_ready, 1'b1);
    instr = mk_opfp(5'h00, 2'b00, 5'd0, 3'b000, 5'd2);
    tick();
    check("bp_full", instr_ready, 1'b0);
    check("bp_headA", rd, 5'd1);
    instr = mk_opfp(5'h00, 2'b00, 5'd0, 3'b000, 5'd3);
    out_ready = 1'b1;
    tick();
    check("bp_rdy_after_pop", instr_ready, 1'b1);
    check("bp_headB", rd, 5'd2);
    out_ready = 1'b0;
    tick();
    check("bp_full2", instr_ready, 1'b0);
    check("bp_hold", rd, 5'd2);
    instr_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_headC", rd, 5'd3);
    tick();
    check("bp_empty", out_valid, 1'b0);

    // Flush beats a simultaneous push
    out_ready = 1'b0; instr_valid = 1'b1; instr = mk_opfp(5'h00, 2'b00, 5'd0, 3'b000, 5'd7);
    tick();
    check("fl_one", out_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    check("fl_vld", out_valid, 1'b0);
    check("fl_rdy", instr_ready, 1'b1);

    // Randomized run against the reference model
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    exp_cnt = 0;
    q.delete();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check("rnd_rdy", instr_ready, q.size() < DEPTH);
      check("rnd_vld", out_valid, q.size() > 0);
      check("rnd_cnt", illegal_cnt, exp_cnt);
      if (q.size() > 0) begin
        obs_r = {op, op_mod, src_fmt, dst_fmt, rnd_mode, rs1, rs2, rs3, rd,
                 fp_we, int_we, load, store, illegal};
        exp_r = q[0];
        msk = '1;
        if (exp_r.illegal) begin
          msk.op = '0; msk.mod = '0; msk.src = '0; msk.dst = '0; msk.rnd = '0;
        end
        check("rnd_head", obs_r & msk, exp_r & msk);
      end
      instr_valid = ($urandom_range(0, 9) < 7);
      instr = rand_instr();
      frm = 3'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      begin
        bit push_m, pop_m;
        push_m = instr_valid && (q.size() < DEPTH);
        pop_m  = out_ready && (q.size() > 0);
        if (pop_m && q[0].illegal && exp_cnt < 32'hFFFF) exp_cnt++;
        if (flush) q.delete();
        else begin
          if (pop_m)  void'(q.pop_front());
          if (push_m) q.push_back(ref_decode(instr, frm, 1'b1));
        end
      end
    end
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0;

    // Reset in the middle of traffic with two entries held
    instr_valid = 1'b1; instr = 32'h0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; instr = mk_opfp(5'h00, 2'b00, 5'd0, 3'b000, 5'd1);
    tick();
    tick();
    instr_valid = 1'b0;
    check("mid_full", {out_valid, instr_ready}, 2'b10);
    check("mid_cnt_nz", illegal_cnt != 16'd0, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 1'b0);
    check("mid_rst_cnt", illegal_cnt, 16'd0);
    check("mid_rst_rdy", instr_ready, 1'b1);
    @(negedge clk);
    rst_ni = 1'b1; out_ready = 1'b1;
    tick();
    check("mid_after", out_valid, 1'b0);

    // Illegal counter saturation on the RVD=0 instance
    n_valid = 1'b1; n_instr = 32'h0; n_oready = 1'b1;
    repeat (1001) @(posedge clk);
    @(negedge clk);
    check("sat_mid", n_cnt, 16'd1000);
    repeat (65000) @(posedge clk);
    @(negedge clk);
    check("sat_top", n_cnt, 16'hFFFF);
    n_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
